hdr_dig_inject: RTL

//  Synchronous-to-asynchronous header injector for the SDM NoC network interface.
//  - Accepts binary hop-count headers from the clocked NI on a valid/ready port.
//  - Re-encodes each 2-bit group as one 1-of-4 digit.
//  - Drives the digits into the asynchronous router input, the upstream feeder of
//    the 1-of-4 decrement stage, using a four-phase return-to-zero handshake.

---
 rtl/hdr_dig_inject.sv | 68 ++++++
 1 files changed

// File: rtl/hdr_dig_inject.sv
// hdr_dig_inject: binary header to 1-of-4 four-phase RTZ injector for the async router input.
// Optional ack timeout flag is enabled by defining HDR_ACK_TIMEOUT_EN.
module hdr_dig_inject #(
  parameter int DW = 2,
  parameter int SYNC = 2,
  parameter int TMO = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [2*DW-1:0] in_hdr,
  output logic [4*DW-1:0] d_o,
  input  logic            ack,
  output logic            busy,
  output logic            err
);
  typedef enum logic [1:0] {IDLE, DATA, NUL} st_t;
  st_t st, st_n;
  logic [SYNC-1:0] sync;
  logic [2*DW-1:0] hbuf;
  logic [4*DW-1:0] enc, d_n;
  logic full, full_n, ack_s, go, acc;
  assign ack_s = sync[SYNC-1];
  assign acc = in_vld && in_rdy;
  assign go = st == IDLE && full && !ack_s;
  assign full_n = acc || (full && !go);
  assign d_n = go ? enc : (st == DATA && !ack_s) ? d_o : '0;
  always_comb begin
    enc = '0;
    for (int i = 0; i < DW; i++) enc[4*i+:4] = 4'b0001 << hbuf[2*i+:2];
  end
  always_comb st_n = go ? DATA : (st == DATA && ack_s) ? NUL : (st == NUL && !ack_s) ? IDLE : st;
  // every output is a flop so the router never sees a combinational glitch
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      sync <= '0;
      hbuf <= '0;
      full <= 1'b0;
      in_rdy <= 1'b0;
      d_o <= '0;
      busy <= 1'b0;
    end else begin
      st <= st_n;
      sync <= {sync[SYNC-2:0], ack};
      if (acc) hbuf <= in_hdr;
      full <= full_n;
      in_rdy <= !full_n;
      d_o <= d_n;
      busy <= st_n != IDLE;
    end
`ifdef HDR_ACK_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  logic [CW-1:0] cnt, cnt_n;
  assign cnt_n = (st_n != st || st == IDLE) ? '0 : (cnt == CW'(TMO)) ? cnt : cnt + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      cnt <= cnt_n;
      if (cnt_n == CW'(TMO)) err <= 1'b1;
    end
`else
  assign err = TMO < 0;
`endif
endmodule
